// File: rtl/nes_palette_loader.sv
// Turns an ioctl palette download (R,G,B byte triplets) into single-cycle 24-bit
// palette RAM writes, and reports how many entries arrived and whether the file was complete.
module nes_palette_loader #(
   parameter logic [7:0] PAL_INDEX  = 8'd2,
   parameter int         NUM_COLORS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        load_color,
   output logic [5:0]  load_color_index,
   output logic [23:0] load_color_data,
   output logic        pal_valid,
   output logic [6:0]  pal_count
);

   typedef enum logic [1:0] {WAIT_END, IDLE, LOAD} state_t;

   localparam logic [6:0] FULL_CNT = 7'(NUM_COLORS);

   state_t     state, state_nxt;
   logic [1:0] phase;
   logic [7:0] exp_addr;
   logic [7:0] r_reg, g_reg;
   logic       full, addr_ok, start;

   assign full    = (pal_count == FULL_CNT);
   assign addr_ok = (ioctl_addr == {17'd0, exp_addr});
   assign start   = ioctl_download && (ioctl_index == PAL_INDEX);

   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_END;
      else       state <= state_nxt;
   end

   // An out-of-sequence address aborts to WAIT_END so the rest of the file is never mis-indexed.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_END: if (!ioctl_download) state_nxt = IDLE;
         IDLE:     if (ioctl_download)  state_nxt = start ? LOAD : WAIT_END;
         LOAD: begin
            if (!ioctl_download)                     state_nxt = IDLE;
            else if (ioctl_wr && !full && !addr_ok) state_nxt = WAIT_END;
         end
         default:                                    state_nxt = WAIT_END;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         load_color       <= 1'b0;
         load_color_index <= '0;
         load_color_data  <= '0;
         pal_valid        <= 1'b0;
         pal_count        <= '0;
         phase            <= '0;
         exp_addr         <= '0;
         r_reg            <= '0;
         g_reg            <= '0;
      end else begin
         load_color <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pal_valid <= 1'b0;
                  pal_count <= '0;
                  phase     <= '0;
                  exp_addr  <= '0;
               end
            end
            LOAD: begin
               if (!ioctl_download) begin
                  pal_valid <= full;
               end else if (ioctl_wr && !full && addr_ok) begin
                  exp_addr <= exp_addr + 8'd1;
                  case (phase)
                     2'd0: begin r_reg <= ioctl_dout; phase <= 2'd1; end
                     2'd1: begin g_reg <= ioctl_dout; phase <= 2'd2; end
                     default: begin
                        load_color       <= 1'b1;
                        load_color_index <= pal_count[5:0];
                        load_color_data  <= {r_reg, g_reg, ioctl_dout};
                        pal_count        <= pal_count + 7'd1;
                        phase            <= 2'd0;
                     end
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule
